// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, single-outstanding memory fetch, prefetch queue and
// redirect flush. Define FETCH_PERF_CNT_EN to add the fetch_count/discard_count outputs.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] fetch_count,
   output logic [15:0] discard_count
`endif
);

   typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

   localparam logic [2:0] Depth  = 3'(QUEUE_DEPTH);
   localparam logic [1:0] PtrMax = 2'(QUEUE_DEPTH - 1);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] target_q, target_d;
   logic [2:0]  count_q, count_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [15:0] q_data [4];
   logic [15:0] q_pc [4];
   logic        ack, push, pop;
   logic [2:0]  occ_after;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == PtrMax) ? 2'd0 : p + 2'd1;
   endfunction

   assign mem_req     = (state_q != StIdle);
   assign mem_addr    = pc_q;
   assign ack         = mem_req && mem_ack;
   assign instr_valid = (count_q != 3'd0) && !redirect_valid;
   assign instr       = (count_q != 3'd0) ? q_data[rd_ptr_q] : 16'h0000;
   assign instr_pc    = (count_q != 3'd0) ? q_pc[rd_ptr_q] : 16'h0000;
   assign pop         = instr_valid && instr_ready;
   // Occupancy after a push on this edge, including any same-cycle pop.
   assign occ_after   = count_q + 3'd1 - {2'b00, pop};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      push     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (count_q < Depth) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (redirect_valid) begin
               if (ack) begin
                  pc_d = redirect_pc;
               end else begin
                  // Keep the outstanding address on the bus until memory answers.
                  target_d = redirect_pc;
                  state_d  = StDrain;
               end
            end else if (ack) begin
               push = 1'b1;
               pc_d = pc_q + 16'd1;
               if (occ_after >= Depth) begin
                  state_d = StIdle;
               end
            end
         end
         StDrain: begin
            if (ack) begin
               pc_d    = redirect_valid ? redirect_pc : target_q;
               state_d = StReq;
            end else if (redirect_valid) begin
               target_d = redirect_pc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect_valid) begin
         count_d  = 3'd0;
         rd_ptr_d = 2'd0;
         wr_ptr_d = 2'd0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + {2'b00, push} - {2'b00, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pc_q     <= RESET_PC;
         target_q <= 16'h0000;
         count_q  <= 3'd0;
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Entry storage needs no reset: the head is masked to zero while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr_q] <= mem_rdata;
         q_pc[wr_ptr_q]   <= pc_q;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic        discard;
   logic [15:0] fetch_cnt_q, discard_cnt_q;

   assign discard = ack && (redirect_valid || state_q == StDrain);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q   <= 16'h0000;
         discard_cnt_q <= 16'h0000;
      end else begin
         if (ack) fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (discard) discard_cnt_q <= discard_cnt_q + 16'd1;
      end
   end

   assign fetch_count   = fetch_cnt_q;
   assign discard_count = discard_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic, all checked every cycle
// against a queue-based reference model.
module tb_instr_fetch_unit;

   localparam logic [15:0] RST_PC = 16'h0010;
   localparam int          DEPTH  = 2;

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] pc;
   } entry_t;

   logic        clk;
   logic        rst_n;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
   logic [15:0] discard_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   entry_t      fifo[$];
   logic        m_busy;
   logic        m_drain;
   logic [15:0] m_addr;
   logic [15:0] m_target;

   instr_fetch_unit #(
      .RESET_PC   (RST_PC),
      .QUEUE_DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count),
      .discard_count (discard_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      fifo.delete();
      m_busy   = 1'b0;
      m_drain  = 1'b0;
      m_addr   = RST_PC;
      m_target = 16'h0000;
   endtask

   task automatic compare();
      entry_t head;
      head = '0;
      if (fifo.size() != 0) head = fifo[0];
      chk("mem_req", 16'(mem_req), 16'(m_busy));
      chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", 16'(instr_valid), 16'((fifo.size() != 0) && !redirect_valid));
      chk("instr", instr, head.data);
      chk("instr_pc", instr_pc, head.pc);
   endtask

   // Apply inputs away from the rising edge, then check outputs against the model.
   task automatic drive(input logic rst, input logic r, input logic [15:0] rpc, input logic ack,
                        input logic rdy);
      @(negedge clk);
      rst_n          = rst;
      redirect_valid = r;
      redirect_pc    = rpc;
      mem_ack        = ack;
      instr_ready    = rdy;
      mem_rdata      = ack ? mem_word(mem_addr) : 16'($urandom);
      #1;
      compare();
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic step();
      int   sz0;
      logic pop;
      logic acked;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
         return;
      end
      sz0   = fifo.size();
      pop   = (sz0 != 0) && !redirect_valid && instr_ready;
      acked = m_busy && mem_ack;
      if (redirect_valid) begin
         fifo.delete();
         if (!m_busy) begin
            m_addr = redirect_pc;
         end else if (acked) begin
            m_addr  = redirect_pc;
            m_drain = 1'b0;
         end else begin
            m_drain  = 1'b1;
            m_target = redirect_pc;
         end
      end else begin
         if (pop) void'(fifo.pop_front());
         if (!m_busy) begin
            m_busy = (sz0 < DEPTH);
         end else if (acked) begin
            if (m_drain) begin
               m_drain = 1'b0;
               m_addr  = m_target;
            end else begin
               fifo.push_back('{data: mem_rdata, pc: m_addr});
               m_addr = m_addr + 16'd1;
               m_busy = (fifo.size() < DEPTH);
            end
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      mem_ack        = 1'b0;
      mem_rdata      = 16'h0000;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      repeat (2) @(posedge clk);
      model_reset();

      // Streaming from reset: ack and ready always high
      drive(1, 0, 0, 1, 1);
      chk("rst_mem_req", 16'(mem_req), 16'd0);
      chk("rst_mem_addr", mem_addr, 16'h0010);
      chk("rst_valid", 16'(instr_valid), 16'd0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_instr_pc", instr_pc, 16'h0000);
      step();
      drive(1, 0, 0, 1, 1);
      chk("first_addr", mem_addr, 16'h0010);
      step();
      drive(1, 0, 0, 1, 1);
      step();
      drive(1, 0, 0, 1, 1);
      chk("stream_addr", mem_addr, 16'h0012);
      chk("stream_pc", instr_pc, 16'h0011);
      step();
      repeat (3) begin
         drive(1, 0, 0, 1, 1);
         step();
      end

      // Stall: restart at 0x0000 with ready low; queue fills and fetch idles
      drive(1, 1, 16'h0000, 1, 0);
      chk("redir_gate", 16'(instr_valid), 16'd0);
      step();
      repeat (6) begin
         drive(1, 0, 0, 1, 0);
         step();
      end
      drive(1, 0, 0, 1, 0);
      chk("stall_req", 16'(mem_req), 16'd0);
      chk("stall_pc", instr_pc, 16'h0000);
      chk("stall_instr", instr, mem_word(16'h0000));
      step();
      repeat (2) begin
         drive(1, 0, 0, 1, 1);
         step();
      end
      // Fetch resumes at 0x0002; redirect to 0x0005 discards this ack
      drive(1, 1, 16'h0005, 1, 1);
      chk("resume_req", 16'(mem_req), 16'd1);
      chk("resume_addr", mem_addr, 16'h0002);
      step();

      // Ack delayed three cycles
      repeat (3) begin
         drive(1, 0, 0, 0, 1);
         chk("wait_req", 16'(mem_req), 16'd1);
         chk("wait_addr", mem_addr, 16'h0005);
         step();
      end
      drive(1, 0, 0, 1, 1);
      step();
      drive(1, 0, 0, 1, 1);
      chk("late_pc", instr_pc, 16'h0005);
      chk("late_instr", instr, mem_word(16'h0005));
      step();

      // Redirect to 0x0100 while 0x0007 is outstanding, ack two cycles later
      drive(1, 1, 16'h0100, 0, 0);
      chk("drain_gate", 16'(instr_valid), 16'd0);
      chk("drain_addr0", mem_addr, 16'h0007);
      step();
      drive(1, 0, 0, 0, 1);
      chk("drain_addr1", mem_addr, 16'h0007);
      chk("drain_valid", 16'(instr_valid), 16'd0);
      step();
      drive(1, 0, 0, 1, 1);
      step();
      drive(1, 0, 0, 1, 1);
      chk("target_addr", mem_addr, 16'h0100);
      step();
      drive(1, 0, 0, 0, 0);
      chk("target_valid", 16'(instr_valid), 16'd1);
      chk("target_pc", instr_pc, 16'h0100);
      step();

      // Address wrap through 0xFFFF
      drive(1, 1, 16'hFFFE, 1, 1);
      step();
      repeat (2) begin
         drive(1, 0, 0, 1, 1);
         step();
      end
      drive(1, 0, 0, 1, 1);
      chk("wrap_addr", mem_addr, 16'h0000);
      chk("wrap_pc_ffff", instr_pc, 16'hFFFF);
      step();
      drive(1, 0, 0, 0, 0);
      chk("wrap_pc_0000", instr_pc, 16'h0000);
      step();

      // Reset mid-request with one queued entry
      drive(0, 0, 0, 0, 0);
      chk("pre_rst_req", 16'(mem_req), 16'd1);
      step();
      drive(1, 0, 0, 0, 0);
      chk("mid_rst_req", 16'(mem_req), 16'd0);
      chk("mid_rst_valid", 16'(instr_valid), 16'd0);
      chk("mid_rst_addr", mem_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
      chk("mid_rst_fetch_cnt", fetch_count, 16'h0000);
      chk("mid_rst_discard_cnt", discard_count, 16'h0000);
`endif
      step();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic        r;
         logic [15:0] rpc;
         r   = ($urandom_range(0, 99) < 4);
         rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                           : 16'($urandom);
         drive(($urandom_range(0, 299) != 0), r, rpc, ($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 60));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Producer side of the 16-bit instruction word consumed by the decode/ALU stage.
- Holds the program counter and fetches words from instruction memory over a single-outstanding req/ack handshake.
- Buffers fetched words in a small prefetch queue and issues them, each with its PC, over a valid/ready interface.
- Accepts a redirect (branch/jump) that flushes the queue and restarts fetch.

Parameters:
RESET_PC, 16'h0000, fetch address loaded on reset.
QUEUE_DEPTH, 2, prefetch queue entries; legal values 1..4.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  16  word address of the current request
mem_ack  input  1  memory accepts the request; mem_rdata valid this cycle
mem_rdata  input  16  fetched instruction word
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr_ready  input  1  decode stage accepts the instruction
instr  output  16  instruction word at queue head
instr_pc  output  16  address of the instruction at queue head
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  16  new fetch address

Behaviour:
- Reset (rst_n low at a clock edge):
  - fetch PC = RESET_PC, queue empty, state IDLE.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Addressing:
  - Word-addressed; fetch PC advances by 1 per accepted fetch.
  - Wraps 16'hFFFF -> 16'h0000 silently.
- Memory handshake:
  - At most one outstanding request.
  - Once mem_req is asserted, mem_req and mem_addr stay stable until the edge where mem_ack=1.
  - mem_rdata is captured on that same edge.
  - mem_ack while mem_req=0 is ignored.
- Credit rule: a request is issued only if (queue occupancy + outstanding requests) < QUEUE_DEPTH.
- State machine:
  - IDLE: mem_req=0. Go to REQ the cycle after a credit is available and no redirect is pending.
  - REQ: mem_req=1.
    - On mem_ack: push {mem_rdata, mem_addr} into the queue and increment fetch PC.
    - If a credit remains after this push (accounting for a same-cycle pop), stay in REQ with the next address. Otherwise go to IDLE.
  - DRAIN: entered when a redirect arrives while in REQ without a same-cycle mem_ack.
    - Hold mem_req=1 and the old mem_addr until mem_ack.
    - Discard the returned data, then go to REQ at the redirect target.
- Issue interface:
  - instr_valid = queue non-empty AND NOT redirect_valid; this is combinational gating.
  - instr/instr_pc are driven from the queue head and are 0 when the queue is empty.
  - Pop occurs on an edge with instr_valid && instr_ready.
  - Once asserted, instr_valid stays high and instr/instr_pc stay stable until the pop, except on redirect.
- Simultaneous push and pop: both take effect; occupancy unchanged. A push into a full queue cannot occur because of the credit rule.
- Redirect:
  - On an edge with redirect_valid=1, the queue is flushed and fetch PC = redirect_pc. No pop occurs that cycle.
  - An ack landing on the redirect edge is discarded; the next state is REQ at redirect_pc.
  - A redirect while in DRAIN overwrites the pending target; the last redirect wins.
- Stall: instr_ready held low fills the queue; fetch then idles, with mem_req=0 in IDLE.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports fetch_count[15:0] and discard_count[15:0], both reset to 0.
  - fetch_count increments on every accepted mem_ack.
  - discard_count increments on every ack whose data is dropped due to redirect.
  - Both wrap at 16'hFFFF.
- Undefined: the ports and counters are absent; fetch behaviour is identical.

Test Plan:
- Reset with RESET_PC=16'h0010, mem_ack always 1, instr_ready=1:
  - mem_addr sequence 0x0010, 0x0011, 0x0012...
  - instr_pc matches, one instr per cycle in steady state.
  - After reset, mem_req=0 and instr_valid=0 until the first fetch.
- instr_ready=0, QUEUE_DEPTH=2, mem_ack=1:
  - exactly 2 fetches (0x0000, 0x0001), then mem_req=0.
  - instr stays at word@0x0000 until ready; raising ready resumes fetch at 0x0002.
- mem_ack delayed 3 cycles:
  - mem_req and mem_addr=0x0005 stable across all stall cycles.
  - data captured only on the ack edge.
- Redirect to 0x0100 while a request to 0x0007 is outstanding, ack 2 cycles later:
  - instr_valid low on the redirect cycle; 0x0007 data never issued.
  - next mem_addr=0x0100; the first issued instr_pc is 0x0100.
- Fetch PC at 16'hFFFF: the next mem_addr is 16'h0000 and the instr_pc sequence continues FFFF -> 0000.
- rst_n low mid-request (mem_req=1, queue holding 1 entry):
  - next cycle mem_req=0, instr_valid=0, mem_addr=RESET_PC.
  - with FETCH_PERF_CNT_EN, both counters read 0.
